// File: rtl/vscale_hpm_counter_bank.sv
// Bank of hardware performance counters with per-counter event select,
// inhibit, sticky overflow and overflow-interrupt enable, decoded on the CSR bus.
// Ports: clk, reset (sync, active-high), addr/wen/wdata (CSR write),
//        rdata/hit (CSR read), events (pipeline pulses), ovf_irq (registered).
module vscale_hpm_counter_bank #(
    parameter int          XPR_LEN    = 32,
    parameter int          NUM_CTRS   = 4,
    parameter int          CTR_WIDTH  = 64,
    parameter int          NUM_EVENTS = 8,
    parameter int          EVT_SEL_W  = 4,
    parameter logic [11:0] BASE_LO    = 12'hC03,
    parameter logic [11:0] BASE_HI    = 12'hC83,
    parameter logic [11:0] BASE_EVT   = 12'h323,
    parameter logic [11:0] ADDR_INH   = 12'h320,
    parameter logic [11:0] ADDR_OVF   = 12'h321,
    parameter logic [11:0] ADDR_OVFIE = 12'h322
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           addr,
    input  logic                  wen,
    input  logic [XPR_LEN-1:0]    wdata,
    output logic [XPR_LEN-1:0]    rdata,
    output logic                  hit,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  ovf_irq
);

    localparam int HW  = CTR_WIDTH - XPR_LEN;
    localparam int EXT = 2 ** EVT_SEL_W;

    logic [CTR_WIDTH-1:0]  ctr [NUM_CTRS];
    logic [EVT_SEL_W-1:0]  sel [NUM_CTRS];
    logic [NUM_CTRS-1:0]   inh;
    logic [NUM_CTRS-1:0]   ovf;
    logic [NUM_CTRS-1:0]   ovfie;
    logic [NUM_EVENTS-1:0] evt_q;

    logic [EXT-1:0]        evt_ext;
    logic [NUM_CTRS-1:0]   inc;
    logic [NUM_CTRS-1:0]   wrap;
    logic [NUM_CTRS-1:0]   lo_wr;
    logic [NUM_CTRS-1:0]   hi_wr;
    logic [NUM_CTRS-1:0]   sel_wr;
    logic [NUM_CTRS-1:0]   ovf_clr;
    logic [11:0]           lo_off;
    logic [11:0]           hi_off;
    logic [11:0]           evt_off;
    logic                  lo_hit;
    logic                  hi_hit;
    logic                  evt_hit;
    logic                  inh_hit;
    logic                  ovf_hit;
    logic                  ovfie_hit;

    // Address decode and per-counter increment qualification
    always_comb begin
        lo_off    = addr - BASE_LO;
        hi_off    = addr - BASE_HI;
        evt_off   = addr - BASE_EVT;
        lo_hit    = 32'(lo_off) < NUM_CTRS;
        hi_hit    = 32'(hi_off) < NUM_CTRS;
        evt_hit   = 32'(evt_off) < NUM_CTRS;
        inh_hit   = addr == ADDR_INH;
        ovf_hit   = addr == ADDR_OVF;
        ovfie_hit = addr == ADDR_OVFIE;
        ovf_clr   = (wen && ovf_hit) ? wdata[NUM_CTRS-1:0] : '0;
        // Pad the event vector so any select value indexes safely
        evt_ext   = '0;
        evt_ext[NUM_EVENTS-1:0] = evt_q;
        for (int i = 0; i < NUM_CTRS; i++) begin
            lo_wr[i]  = wen && lo_hit && (lo_off == 12'(i));
            hi_wr[i]  = wen && hi_hit && (hi_off == 12'(i));
            sel_wr[i] = wen && evt_hit && (evt_off == 12'(i));
            inc[i]    = !inh[i] && (sel[i] != '0)
                     && (32'(sel[i]) < NUM_EVENTS)
                     && evt_ext[sel[i]];
            // A write to either half takes priority and drops the increment
            wrap[i]   = inc[i] && !lo_wr[i] && !hi_wr[i] && (&ctr[i]);
        end
    end

    // Read mux
    always_comb begin
        hit   = lo_hit | hi_hit | evt_hit | inh_hit | ovf_hit | ovfie_hit;
        rdata = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (lo_hit && lo_off == 12'(i))
                rdata = ctr[i][XPR_LEN-1:0];
            if (hi_hit && hi_off == 12'(i))
                rdata = XPR_LEN'(ctr[i][CTR_WIDTH-1:XPR_LEN]);
            if (evt_hit && evt_off == 12'(i))
                rdata = XPR_LEN'(sel[i]);
        end
        if (inh_hit)   rdata = XPR_LEN'(inh);
        if (ovf_hit)   rdata = XPR_LEN'(ovf);
        if (ovfie_hit) rdata = XPR_LEN'(ovfie);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q   <= '0;
            inh     <= '0;
            ovf     <= '0;
            ovfie   <= '0;
            ovf_irq <= 1'b0;
            for (int i = 0; i < NUM_CTRS; i++) begin
                ctr[i] <= '0;
                sel[i] <= '0;
            end
        end else begin
            evt_q   <= events;
            ovf_irq <= |(ovf & ovfie);
            // Set from a wrap wins over a same-cycle W1C
            ovf     <= (ovf & ~ovf_clr) | wrap;
            if (wen && inh_hit)
                inh <= wdata[NUM_CTRS-1:0];
            if (wen && ovfie_hit)
                ovfie <= wdata[NUM_CTRS-1:0];
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (sel_wr[i])
                    sel[i] <= wdata[EVT_SEL_W-1:0];
                if (lo_wr[i])
                    ctr[i][XPR_LEN-1:0] <= wdata;
                else if (hi_wr[i])
                    ctr[i][CTR_WIDTH-1:XPR_LEN] <= wdata[HW-1:0];
                else if (inc[i])
                    ctr[i] <= ctr[i] + CTR_WIDTH'(1);
            end
        end
    end

endmodule
